// File: rtl/booth_sched_pkg.sv
// Shared types and default sizes for the Booth multiplier scheduler.
// The optional round-robin arbitration is enabled by defining BOOTH_SCHED_RR_EN.
package booth_sched_pkg;

  localparam int DEF_W    = 8;
  localparam int DEF_NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/booth_seq_core.sv
// Sequential radix-2 Booth multiplier datapath: one step per enabled cycle.
// start loads the operands and clears the accumulator and step counter; done
// stays high once W steps have been performed, with product valid alongside.
// The accumulator carries one guard bit so that -Y for Y = -2^(W-1) and the
// product (-2^(W-1))^2 remain exact.
module booth_seq_core
  import booth_sched_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int CW = $clog2(W + 1);

  logic signed [W:0] acc_r;
  logic [W-1:0]      q_r;
  logic              q1_r;
  logic [W-1:0]      y_r;
  logic [CW-1:0]     cnt_r;

  logic signed [W:0] y_ext_s;
  logic signed [W:0] sum_s;
  logic              step_s;

  // Booth recoding of {X[i], X[i-1]}: add -Y, add +Y, or pass the accumulator.
  always_comb begin
    y_ext_s = {y_r[W-1], y_r};
    step_s  = run && (cnt_r != CW'(W));
    case ({q_r[0], q1_r})
      2'b10:   sum_s = acc_r - y_ext_s;
      2'b01:   sum_s = acc_r + y_ext_s;
      default: sum_s = acc_r;
    endcase
  end

  // Operand load on start, then add-and-arithmetic-shift once per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
      q_r   <= '0;
      q1_r  <= 1'b0;
      y_r   <= '0;
      cnt_r <= '0;
    end else if (start) begin
      acc_r <= '0;
      q_r   <= x;
      q1_r  <= 1'b0;
      y_r   <= y;
      cnt_r <= '0;
    end else if (step_s) begin
      acc_r <= {sum_s[W], sum_s[W:1]};
      q_r   <= {sum_s[0], q_r[W-1:1]};
      q1_r  <= q_r[0];
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign done    = (cnt_r == CW'(W));
  assign product = {acc_r[W-1:0], q_r};

endmodule

// File: rtl/booth_mult_scheduler.sv
// Arbitrates NREQ requesters onto one sequential Booth multiplier and returns
// the signed product with the owning requester index.
// Define BOOTH_SCHED_RR_EN for round-robin arbitration; otherwise the lowest
// asserted request index wins.
module booth_mult_scheduler
  import booth_sched_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  parameter  int W    = DEF_W,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_x,
  input  logic [NREQ*W-1:0]   req_y,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [2*W-1:0]      resp_data,
  output logic [IDW-1:0]      resp_id,
  output logic                busy
);

  sched_state_t   state_r;
  sched_state_t   state_s;
  logic           grant_found_s;
  logic [IDW-1:0] grant_idx_s;
  logic           accept_s;
  logic [IDW-1:0] id_r;
  logic           resp_valid_r;
  logic [2*W-1:0] resp_data_r;
  logic [IDW-1:0] resp_id_r;
  logic           busy_r;
  logic           core_done_s;
  logic [2*W-1:0] core_product_s;

`ifdef BOOTH_SCHED_RR_EN
  logic [IDW-1:0] ptr_r;

  // Round-robin search: first asserted request at or after the pointer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found_s && req_valid[(int'(ptr_r) + k) % NREQ]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IDW'((int'(ptr_r) + k) % NREQ);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Pointer moves just past the requester that was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      ptr_r <= (grant_idx_s == IDW'(NREQ - 1)) ? '0 : grant_idx_s + IDW'(1);
    end
  end
`else
  // Fixed priority: lowest asserted request index wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found_s && req_valid[i]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IDW'(i);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end
`endif

  // Grant is offered only while idle, to the arbitration winner alone.
  always_comb begin
    req_ready = '0;
    if ((state_r == IDLE) && grant_found_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s = |(req_valid & req_ready);

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (core_done_s) state_s = DONE;
        else             state_s = RUN;
      end
      DONE: begin
        if (resp_ready) state_s = IDLE;
        else            state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, captured requester id and the registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      id_r         <= '0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= '0;
      resp_id_r    <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      resp_valid_r <= (state_s == DONE);
      busy_r       <= (state_s != IDLE);
      if (accept_s) begin
        id_r <= grant_idx_s;
      end
      if ((state_r == RUN) && (state_s == DONE)) begin
        resp_data_r <= core_product_s;
        resp_id_r   <= id_r;
      end
    end
  end

  booth_seq_core #(.W(W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_s),
    .run     (state_r == RUN),
    .x       (req_x[int'(grant_idx_s) * W +: W]),
    .y       (req_y[int'(grant_idx_s) * W +: W]),
    .done    (core_done_s),
    .product (core_product_s)
  );

  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_id    = resp_id_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Self-checking bench for booth_mult_scheduler: table of directed operations,
// randomized operations against an arithmetic product model, plus reset and
// arbitration-order sequences. Honours BOOTH_SCHED_RR_EN for expected grants.
module tb_booth_mult_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic              resp_valid;
  logic              resp_ready;
  logic [2*W-1:0]    resp_data;
  logic [1:0]        resp_id;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int                     r;
    logic signed [W-1:0]    x;
    logic signed [W-1:0]    y;
    logic signed [2*W-1:0]  p;
    int                     hold;
  } vec_t;

  vec_t tbl[5];

  booth_mult_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic signed [2*W-1:0] model_mul(input logic signed [W-1:0] a,
                                                      input logic signed [W-1:0] b);
    return (2*W)'(int'(a) * int'(b));
  endfunction

  function automatic int model_pick(input int ptr, input logic [NREQ-1:0] v);
    int start;
`ifdef BOOTH_SCHED_RR_EN
    start = ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int r, input logic signed [W-1:0] x,
                        input logic signed [W-1:0] y, input logic signed [2*W-1:0] p,
                        input int hold);
    int lat;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    req_valid = oh;
    req_x[r*W +: W] = x;
    req_y[r*W +: W] = y;
    resp_ready = 1'b0;
    #1;
    chk("req_ready_grant", 32'(req_ready), 32'(oh));
    tick();
    req_valid = '0;
    req_x = 32'($urandom());
    req_y = 32'($urandom());
    chk("busy_in_run", 32'(busy), 32'd1);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("resp_latency", 32'(lat), 32'(W + 1));
    chk("resp_data", 32'($unsigned(resp_data)), 32'($unsigned(p)));
    chk("resp_id", 32'(resp_id), 32'(r));
    if (hold > 0) begin
      req_valid = 4'b0001;
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_data", 32'($unsigned(resp_data)), 32'($unsigned(p)));
        chk("hold_id", 32'(resp_id), 32'(r));
        chk("hold_no_ready", 32'(req_ready), 32'd0);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("released_valid", 32'(resp_valid), 32'd0);
    if (hold > 0) begin
      chk("bubble_grant", 32'(req_ready), 32'd1);
      tick();
      chk("next_accepted", 32'(busy), 32'd1);
      req_valid = '0;
      resp_ready = 1'b1;
      lat = 0;
      while (busy && lat < 40) begin
        tick();
        lat++;
      end
      chk("drain_idle", 32'(busy), 32'd0);
      resp_ready = 1'b0;
    end else begin
      chk("released_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int seen;
    int w;
    int e;
    int last;
    int ptr_m;
    logic [NREQ-1:0] oh;
    logic signed [W-1:0] rx;
    logic signed [W-1:0] ry;

    tbl[0] = '{r: 2, x:  8'sd5,    y: -8'sd3,   p: -16'sd15,    hold: 0};
    tbl[1] = '{r: 0, x: -8'sd128,  y: -8'sd128, p:  16'sd16384, hold: 0};
    tbl[2] = '{r: 1, x:  8'sd127,  y: -8'sd128, p: -16'sd16256, hold: 2};
    tbl[3] = '{r: 3, x:  8'sd0,    y:  8'sd99,  p:  16'sd0,     hold: 0};
    tbl[4] = '{r: 2, x: -8'sd7,    y:  8'sd9,   p: -16'sd63,    hold: 5};

    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", 32'(resp_data), 32'd0);
    chk("reset_resp_id", 32'(resp_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].r, tbl[i].x, tbl[i].y, tbl[i].p, tbl[i].hold);
    end

    for (int i = 0; i < 20; i++) begin
      rx = W'($urandom());
      ry = W'($urandom());
      run_op($urandom_range(0, NREQ - 1), rx, ry, model_mul(rx, ry), $urandom_range(0, 2));
    end

    // Reset in the middle of RUN discards the operation.
    req_valid = 4'b0010;
    req_x[1*W +: W] = 8'sd11;
    req_y[1*W +: W] = 8'sd13;
    #1;
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_valid", 32'(resp_valid), 32'd0);
    chk("midrun_rst_data", 32'(resp_data), 32'd0);
    chk("midrun_rst_id", 32'(resp_id), 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    chk("no_ghost_response", 32'(seen), 32'd0);
    run_op(1, 8'sd11, 8'sd13, 16'sd143, 0);

    // Reset wins over a simultaneous accept.
    req_valid = 4'b0100;
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    req_valid = '0;
    chk("rst_over_accept", 32'(busy), 32'd0);
    run_op(3, -8'sd1, -8'sd1, 16'sd1, 0);

    // All requesters held valid: check grant order and the turnaround gap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr_m = 0;
    last = 0;
    req_x = 32'($urandom());
    req_y = 32'($urandom());
    req_valid = '1;
    resp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (req_ready == '0 && w < 40) begin
        tick();
        w++;
      end
      e = model_pick(ptr_m, req_valid);
      oh = '0;
      if (e >= 0) oh[e] = 1'b1;
      chk("grant_order", 32'(req_ready), 32'(oh));
      if (g > 0) chk("grant_gap", 32'(cyc - last), 32'(W + 3));
      last = cyc;
`ifdef BOOTH_SCHED_RR_EN
      ptr_m = (e + 1) % NREQ;
`endif
      tick();
    end
    req_valid = '0;
    w = 0;
    while (busy && w < 40) begin
      tick();
      w++;
    end
    chk("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
